// File: rtl/sha1_round_ctrl_if.sv
// Command/status bundle between the SHA-1 Wishbone register block and the round engine.
// The register block drives the master side; the round engine sits on the slave side.
interface sha1_round_ctrl_if;
  logic         start_i;
  logic         init_i;
  logic         soft_rst_i;
  logic [511:0] message_i;
  logic [159:0] digest_o;
  logic         busy_o;
  logic         done_o;
  logic         panic_o;
  logic [6:0]   loop_idx_o;

  modport master (
    output start_i, init_i, soft_rst_i, message_i,
    input  digest_o, busy_o, done_o, panic_o, loop_idx_o
  );

  modport slave (
    input  start_i, init_i, soft_rst_i, message_i,
    output digest_o, busy_o, done_o, panic_o, loop_idx_o
  );
endinterface

// File: rtl/sha1_round_ctrl.sv
// SHA-1 compression sequencer: loads one 512-bit block, runs ROUNDS rounds one per
// cycle, then folds the working variables into the chaining digest.
module sha1_round_ctrl #(
  parameter int unsigned ROUNDS = 80
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  sha1_round_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [159:0] IV = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE,
                                 32'hEFCDAB89, 32'h67452301};
  localparam logic [6:0]   LAST_T = 7'(ROUNDS - 1);

  state_t             state_q, state_d;
  logic [4:0][31:0]   h_q, h_d;
  logic [15:0][31:0]  w_q, w_d;
  logic [31:0]        a_q, b_q, c_q, d_q, e_q;
  logic [31:0]        a_d, b_d, c_d, d_d, e_d;
  logic [6:0]         t_q, t_d;
  logic               panic_q, panic_d;

  logic [31:0]        f, k, tmp, w_next;
  logic               busy;

  assign busy = (state_q == S_LOAD) || (state_q == S_ROUND) || (state_q == S_FINAL);

  // Round function and schedule; only consumed in S_ROUND.
  always_comb begin
    if (t_q < 7'd20) begin
      f = (b_q & c_q) | (~b_q & d_q);
      k = 32'h5A827999;
    end else if (t_q < 7'd40) begin
      f = b_q ^ c_q ^ d_q;
      k = 32'h6ED9EBA1;
    end else if (t_q < 7'd60) begin
      f = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
      k = 32'h8F1BBCDC;
    end else begin
      f = b_q ^ c_q ^ d_q;
      k = 32'hCA62C1D6;
    end
    tmp    = {a_q[26:0], a_q[31:27]} + f + e_q + k + w_q[0];
    w_next = w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0];
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    w_d     = w_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    e_d     = e_q;
    t_d     = t_q;
    panic_d = panic_q;

    if (bus.soft_rst_i) begin
      state_d = S_IDLE;
      h_d     = IV;
      t_d     = '0;
      panic_d = 1'b0;
    end else begin
      if (busy && bus.start_i) begin
        panic_d = 1'b1;
      end
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start_i) begin
            w_d     = bus.message_i;
            panic_d = 1'b0;
            state_d = S_LOAD;
            if (bus.init_i) begin
              h_d = IV;
            end
          end
        end
        S_LOAD: begin
          a_d     = h_q[0];
          b_d     = h_q[1];
          c_d     = h_q[2];
          d_d     = h_q[3];
          e_d     = h_q[4];
          t_d     = '0;
          state_d = S_ROUND;
        end
        S_ROUND: begin
          // W[0] always holds W[t]; the new tail word is W[t+16].
          w_d = {{w_next[30:0], w_next[31]}, w_q[15:1]};
          e_d = d_q;
          d_d = c_q;
          c_d = {b_q[1:0], b_q[31:2]};
          b_d = a_q;
          a_d = tmp;
          if (t_q == LAST_T) begin
            t_d     = '0;
            state_d = S_FINAL;
          end else begin
            t_d = t_q + 7'd1;
          end
        end
        S_FINAL: begin
          h_d[0]  = h_q[0] + a_q;
          h_d[1]  = h_q[1] + b_q;
          h_d[2]  = h_q[2] + c_q;
          h_d[3]  = h_q[3] + d_q;
          h_d[4]  = h_q[4] + e_q;
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      h_q     <= IV;
      w_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      t_q     <= '0;
      panic_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      w_q     <= w_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      e_q     <= e_d;
      t_q     <= t_d;
      panic_q <= panic_d;
    end
  end

  assign bus.digest_o   = h_q;
  assign bus.busy_o     = busy;
  assign bus.done_o     = (state_q == S_DONE);
  assign bus.panic_o    = panic_q;
  assign bus.loop_idx_o = (state_q == S_ROUND) ? t_q : '0;

endmodule

// File: tb/tb_sha1_round_ctrl.sv
// Bench for sha1_round_ctrl: known-answer vectors, random chained blocks against a
// plain SHA-1 compression model, and abort/panic/reset sequences.
module tb_sha1_round_ctrl;

  localparam int ROUNDS = 80;
  localparam logic [159:0] IV = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE,
                                 32'hEFCDAB89, 32'h67452301};
  localparam logic [159:0] ABC_D = {32'h9CD0D89D, 32'h7850C26C, 32'hBA3E2571,
                                    32'h4706816A, 32'hA9993E36};

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  logic [159:0] model_h;

  sha1_round_ctrl_if bus ();

  sha1_round_ctrl #(.ROUNDS(ROUNDS)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             init;
    logic [15:0][31:0] w;
    logic [159:0]     exp;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [159:0] ref_compress(input logic [159:0] h, input logic [511:0] m);
    logic [31:0] w[80];
    logic [31:0] a, b, c, d, e, f, k, tmp, x;
    for (int i = 0; i < 16; i++) w[i] = m[32*i +: 32];
    for (int i = 16; i < 80; i++) begin
      x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {x[30:0], x[31]};
    end
    a = h[31:0]; b = h[63:32]; c = h[95:64]; d = h[127:96]; e = h[159:128];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {h[159:128] + e, h[127:96] + d, h[95:64] + c, h[63:32] + b, h[31:0] + a};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idx(input int t);
    int n = 0;
    while (bus.loop_idx_o != 7'(t) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("reach_t%0d", t), {159'd0, n < 300}, 160'd1);
  endtask

  // Called at a negedge; leaves the bench at the negedge where done_o was seen.
  task automatic run_block(input string name, input logic init, input logic [511:0] m,
                           input int poke_t, input logic [159:0] exp);
    logic [159:0] h_before;
    int  lat;
    logic idx_ok, stable_ok, poked;
    h_before = init ? IV : bus.digest_o;
    bus.start_i   = 1'b1;
    bus.init_i    = init;
    bus.message_i = m;
    @(negedge clk);
    bus.start_i   = 1'b0;
    bus.init_i    = ~init;
    for (int i = 0; i < 16; i++) bus.message_i[32*i +: 32] = $urandom;
    chk({name, "_busy"},  {159'd0, bus.busy_o},  160'd1);
    chk({name, "_done0"}, {159'd0, bus.done_o},  160'd0);
    chk({name, "_panic0"}, {159'd0, bus.panic_o}, 160'd0);
    lat = 0; idx_ok = 1'b1; stable_ok = 1'b1; poked = 1'b0;
    while (!bus.done_o && lat < 200) begin
      if (bus.loop_idx_o != ((lat >= 1 && lat <= ROUNDS) ? 7'(lat - 1) : 7'd0) || !bus.busy_o)
        idx_ok = 1'b0;
      if (bus.digest_o !== h_before) stable_ok = 1'b0;
      if (bus.start_i) begin
        bus.start_i = 1'b0;
      end else if (poke_t >= 0 && !poked && bus.loop_idx_o == 7'(poke_t)) begin
        bus.start_i = 1'b1;
        bus.init_i  = 1'b1;
        poked = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 160'(lat), 160'(ROUNDS + 2));
    chk({name, "_loopidx"}, {159'd0, idx_ok}, 160'd1);
    chk({name, "_stable"},  {159'd0, stable_ok}, 160'd1);
    chk({name, "_digest"},  bus.digest_o, exp);
    chk({name, "_panic"},   {159'd0, bus.panic_o}, {159'd0, poke_t >= 0});
    model_h = exp;
  endtask

  initial begin
    logic [511:0] m;
    logic         ini;

    vecs[0].name = "abc";   vecs[0].init = 1'b1; vecs[0].w = '0;
    vecs[0].w[0] = 32'h61626380; vecs[0].w[15] = 32'h00000018; vecs[0].exp = ABC_D;
    vecs[1].name = "empty"; vecs[1].init = 1'b1; vecs[1].w = '0;
    vecs[1].w[0] = 32'h80000000;
    vecs[1].exp = {32'hAFD80709, 32'h95601890, 32'h3255BFEF, 32'h5E6B4B0D, 32'hDA39A3EE};
    vecs[2].name = "two_b1"; vecs[2].init = 1'b1;
    vecs[2].w = {32'h00000000, 32'h80000000, 32'h6e6f7071, 32'h6d6e6f70,
                 32'h6c6d6e6f, 32'h6b6c6d6e, 32'h6a6b6c6d, 32'h696a6b6c,
                 32'h68696a6b, 32'h6768696a, 32'h66676869, 32'h65666768,
                 32'h64656667, 32'h63646566, 32'h62636465, 32'h61626364};
    vecs[2].exp = ref_compress(IV, vecs[2].w);
    vecs[3].name = "two_b2"; vecs[3].init = 1'b0; vecs[3].w = '0;
    vecs[3].w[15] = 32'h000001C0;
    vecs[3].exp = {32'hE54670F1, 32'hF95129E5, 32'hBAAE4AA1, 32'h1C3BD26E, 32'h84983E44};

    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.init_i = 1'b0; bus.soft_rst_i = 1'b0; bus.message_i = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_digest", bus.digest_o, IV);
    chk("rst_flags", {156'd0, bus.busy_o, bus.done_o, bus.panic_o, 1'b0}, 160'd0);
    chk("rst_idx", {153'd0, bus.loop_idx_o}, 160'd0);
    rst_n = 1'b1;
    @(negedge clk);
    model_h = IV;

    for (int i = 0; i < 4; i++)
      run_block(vecs[i].name, vecs[i].init, vecs[i].w, -1, vecs[i].exp);

    // Random blocks, chained or freshly initialised, against the model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
      ini = 1'($urandom_range(0, 1));
      run_block($sformatf("rand%0d", r), ini, m, -1, ref_compress(ini ? IV : model_h, m));
    end

    // Start while busy: ignored, flagged; next start from DONE clears it.
    run_block("panic", 1'b1, vecs[0].w, 10, ABC_D);
    run_block("after_panic", 1'b1, vecs[1].w, -1, vecs[1].exp);

    // Chained run aborted by soft reset after a panic.
    for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
    bus.start_i = 1'b1; bus.init_i = 1'b0; bus.message_i = m;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_idx(10);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_idx(40);
    chk("sr_panic_before", {159'd0, bus.panic_o}, 160'd1);
    chk("sr_digest_before", bus.digest_o, model_h);
    bus.soft_rst_i = 1'b1;
    @(negedge clk);
    bus.soft_rst_i = 1'b0;
    chk("sr_flags", {157'd0, bus.busy_o, bus.done_o, bus.panic_o}, 160'd0);
    chk("sr_idx", {153'd0, bus.loop_idx_o}, 160'd0);
    chk("sr_digest", bus.digest_o, IV);
    bus.soft_rst_i = 1'b1; bus.start_i = 1'b1; bus.init_i = 1'b1;
    @(negedge clk);
    bus.soft_rst_i = 1'b0; bus.start_i = 1'b0;
    @(negedge clk);
    chk("sr_start_flags", {157'd0, bus.busy_o, bus.done_o, bus.panic_o}, 160'd0);
    model_h = IV;
    for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
    run_block("post_sr_chain", 1'b0, m, -1, ref_compress(IV, m));

    // Asynchronous reset in the middle of a run.
    bus.start_i = 1'b1; bus.init_i = 1'b1; bus.message_i = vecs[1].w;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_idx(30);
    rst_n = 1'b0;
    #1;
    chk("arst_flags", {157'd0, bus.busy_o, bus.done_o, bus.panic_o}, 160'd0);
    chk("arst_idx", {153'd0, bus.loop_idx_o}, 160'd0);
    chk("arst_digest", bus.digest_o, IV);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block("post_arst_abc", 1'b1, vecs[0].w, -1, ABC_D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
